// File: rtl/relu_maxpool_pkg.sv
// Shared CNN defaults and the pooling FSM state type.
// Optional build macro RELU_POOL_RELU_EN (used by max4_s8) adds a ReLU clamp before pooling.
package cnn_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_H          = 24;
    localparam int DEF_K          = 8;
    localparam int DEF_ROWS       = 24;

    // IDLE: no row buffered, HOLD: even row buffered and waiting for its pair
    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t HOLD = 1'b1;

endpackage

// File: rtl/relu_maxpool_if.sv
// Row-in / pooled-row-out bus between the requant stage and relu_maxpool.
interface relu_maxpool_if
    import cnn_pkg::*;
#(
    parameter int H          = DEF_H,
    parameter int K          = DEF_K,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic [0:H*K*DATA_WIDTH-1]     row_i;
    logic                          done_add_i;
    logic [0:(H/2)*K*DATA_WIDTH-1] pool_o;
    logic                          done_pool_o;
    logic                          frame_done_o;
    logic                          busy_o;

    // upstream producer / downstream consumer side
    modport master (
        output row_i, done_add_i,
        input  pool_o, done_pool_o, frame_done_o, busy_o
    );

    // pooling block side
    modport slave (
        input  row_i, done_add_i,
        output pool_o, done_pool_o, frame_done_o, busy_o
    );

endinterface

// File: rtl/relu_maxpool_max4.sv
// Combinational signed max of a 2x2 window.
// With RELU_POOL_RELU_EN defined every input is clamped to max(x,0) first,
// so the result is never negative.
module max4_s8 #(
    parameter int DATA_WIDTH = 8
) (
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    input  logic signed [DATA_WIDTH-1:0] c,
    input  logic signed [DATA_WIDTH-1:0] d,
    output logic signed [DATA_WIDTH-1:0] y
);

    function automatic logic signed [DATA_WIDTH-1:0] act(input logic signed [DATA_WIDTH-1:0] x);
`ifdef RELU_POOL_RELU_EN
        return x[DATA_WIDTH-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    logic signed [DATA_WIDTH-1:0] va, vb, vc, vd, m_ab, m_cd;

    // activation, then a two-level compare tree; ties keep the equal value
    always_comb begin
        va   = act(a);
        vb   = act(b);
        vc   = act(c);
        vd   = act(d);
        m_ab = (va > vb) ? va : vb;
        m_cd = (vc > vd) ? vc : vd;
        y    = (m_ab > m_cd) ? m_ab : m_cd;
    end

endmodule

// File: rtl/relu_maxpool.sv
// 2x2 max-pool (optionally ReLU, macro RELU_POOL_RELU_EN) over pairs of int8 rows.
// The even row of each pair is buffered; when the odd row arrives all
// H/2*K windows are reduced in one cycle and registered into pool_o.
module relu_maxpool
    import cnn_pkg::*;
#(
    parameter int H          = DEF_H,
    parameter int K          = DEF_K,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ROWS       = DEF_ROWS
) (
    input  logic          clk,
    input  logic          rst_n,
    relu_maxpool_if.slave bus
);

    localparam int HP = H / 2;
    localparam int RW = H * K * DATA_WIDTH;
    localparam int PW = HP * K * DATA_WIDTH;
    localparam int CW = (ROWS > 2) ? $clog2(ROWS) : 1;

    state_t          state;
    logic [CW-1:0]   row_cnt;
    logic [0:RW-1]   row_buf;
    logic [0:PW-1]   pool_win;
    logic [0:PW-1]   pool_q;
    logic            done_q;
    logic            frame_q;
    logic            pair_fire;

    assign pair_fire = bus.done_add_i && (state == HOLD);

    // one window reducer per (channel, output position)
    for (genvar m = 0; m < K; m++) begin : g_ch
        for (genvar p = 0; p < HP; p++) begin : g_pos
            max4_s8 #(.DATA_WIDTH(DATA_WIDTH)) u_max (
                .a (row_buf   [(m*H + 2*p)     * DATA_WIDTH +: DATA_WIDTH]),
                .b (row_buf   [(m*H + 2*p + 1) * DATA_WIDTH +: DATA_WIDTH]),
                .c (bus.row_i [(m*H + 2*p)     * DATA_WIDTH +: DATA_WIDTH]),
                .d (bus.row_i [(m*H + 2*p + 1) * DATA_WIDTH +: DATA_WIDTH]),
                .y (pool_win  [(m*HP + p)      * DATA_WIDTH +: DATA_WIDTH])
            );
        end
    end

    // pairing FSM and frame row counter; every accepted row toggles the pair phase
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state   <= IDLE;
            row_cnt <= '0;
        end else if (bus.done_add_i) begin
            state   <= (state == IDLE) ? HOLD : IDLE;
            row_cnt <= (row_cnt == CW'(ROWS - 1)) ? '0 : row_cnt + 1'b1;
        end
    end

    // even row capture; kept after pooling, only overwritten by the next even row
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            row_buf <= '0;
        end else if (bus.done_add_i && (state == IDLE)) begin
            row_buf <= bus.row_i;
        end
    end

    // pooled result register and its single-cycle strobes
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            pool_q  <= '0;
            done_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            if (pair_fire) pool_q <= pool_win;
            done_q  <= pair_fire;
            frame_q <= pair_fire && (row_cnt == CW'(ROWS - 1));
        end
    end

    assign bus.pool_o       = pool_q;
    assign bus.done_pool_o  = done_q;
    assign bus.frame_done_o = frame_q;
    assign bus.busy_o       = (state == HOLD);

endmodule

// File: tb/tb_relu_maxpool.sv
// Directed + random bench for relu_maxpool with a row-level reference model.
module tb_relu_maxpool;

    localparam int H    = 24;
    localparam int K    = 8;
    localparam int DW   = 8;
    localparam int ROWS = 4;
    localparam int HP   = H / 2;
    localparam int RW   = H * K * DW;
    localparam int PW   = HP * K * DW;

    typedef logic [0:RW-1] row_t;
    typedef logic [0:PW-1] pool_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    relu_maxpool_if #(.H(H), .K(K), .DATA_WIDTH(DW)) bus ();

    relu_maxpool #(.H(H), .K(K), .DATA_WIDTH(DW), .ROWS(ROWS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int    checks = 0;
    int    passed = 0;
    int    fails  = 0;
    int    accepted = 0;
    row_t  prev_row = '0;
    pool_t exp_pool = '0;
    logic  exp_done = 1'b0;
    logic  exp_frame = 1'b0;
    pool_t pool_a;

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int el(input row_t r, input int m, input int n);
        logic signed [DW-1:0] v;
        v = r[(m*H + n)*DW +: DW];
        return int'(v);
    endfunction

    // 2x2 window max straight from the element definition
    function automatic pool_t ref_pool(input row_t a, input row_t b);
        pool_t r;
        r = '0;
        for (int m = 0; m < K; m++) begin
            for (int p = 0; p < HP; p++) begin
                int v[4];
                int mx;
                logic [DW-1:0] t;
                v[0] = el(a, m, 2*p);
                v[1] = el(a, m, 2*p+1);
                v[2] = el(b, m, 2*p);
                v[3] = el(b, m, 2*p+1);
                mx = v[0];
                for (int i = 1; i < 4; i++) if (v[i] > mx) mx = v[i];
`ifdef RELU_POOL_RELU_EN
                if (mx < 0) mx = 0;
`endif
                t = mx[DW-1:0];
                r[(m*HP + p)*DW +: DW] = t;
            end
        end
        return r;
    endfunction

    function automatic row_t fill(input int v);
        row_t r;
        for (int i = 0; i < H*K; i++) r[i*DW +: DW] = DW'(v);
        return r;
    endfunction

    function automatic pool_t pfill(input int v);
        pool_t r;
        for (int i = 0; i < HP*K; i++) r[i*DW +: DW] = DW'(v);
        return r;
    endfunction

    function automatic row_t rand_row();
        row_t r;
        for (int i = 0; i < RW/32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // one clock: drive at negedge, update the model, check at the next negedge
    task automatic tick(input bit add, input row_t row, input string tag);
        bus.done_add_i = add;
        bus.row_i      = row;
        exp_done  = 1'b0;
        exp_frame = 1'b0;
        if (add) begin
            accepted++;
            if (accepted % 2 == 0) begin
                exp_pool  = ref_pool(prev_row, row);
                exp_done  = 1'b1;
                exp_frame = (accepted % ROWS == 0);
            end else begin
                prev_row = row;
            end
        end
        @(negedge clk);
        chk({tag, " pool"},  bus.pool_o,       exp_pool);
        chk({tag, " done"},  bus.done_pool_o,  exp_done);
        chk({tag, " frame"}, bus.frame_done_o, exp_frame);
        chk({tag, " busy"},  bus.busy_o,       (accepted % 2 == 1));
        bus.done_add_i = 1'b0;
    endtask

    // hold reset with row pulses present; they must be ignored
    task automatic do_reset(input int cycles);
        rst_n = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            bus.done_add_i = 1'b1;
            bus.row_i      = rand_row();
            @(negedge clk);
        end
        accepted  = 0;
        exp_pool  = '0;
        exp_done  = 1'b0;
        exp_frame = 1'b0;
        chk("rst pool",  bus.pool_o,       '0);
        chk("rst done",  bus.done_pool_o,  1'b0);
        chk("rst frame", bus.frame_done_o, 1'b0);
        chk("rst busy",  bus.busy_o,       1'b0);
        bus.done_add_i = 1'b0;
        rst_n = 1'b0;
    endtask

    initial begin
        bus.done_add_i = 1'b0;
        bus.row_i      = '0;
        @(negedge clk);
        do_reset(3);

        // rows of 5 and 9, an idle cycle between them
        tick(1'b1, fill(5), "r31a");
        tick(1'b0, fill(5), "r31idle");
        tick(1'b1, fill(9), "r31b");
        chk("r31 all9", bus.pool_o, pfill(9));
        tick(1'b0, fill(0), "r31after");

        // signed extremes in ch0, random elsewhere; this pair closes the frame
        begin
            row_t a, b;
            a = rand_row();
            b = rand_row();
            a[0*DW +: DW] = 8'(-3);   a[1*DW +: DW] = 8'(7);
            a[2*DW +: DW] = 8'(-128); a[3*DW +: DW] = 8'(127);
            b[0*DW +: DW] = 8'(2);    b[1*DW +: DW] = 8'(-1);
            b[2*DW +: DW] = 8'(0);    b[3*DW +: DW] = 8'(-5);
            tick(1'b1, a, "r32a");
            tick(1'b1, b, "r32b");
            chk("r32 p0", bus.pool_o[0 +: DW],  8'd7);
            chk("r32 p1", bus.pool_o[DW +: DW], 8'd127);
        end

        // all-negative rows
        tick(1'b1, fill(-20), "r33a");
        tick(1'b1, fill(-20), "r33b");
`ifdef RELU_POOL_RELU_EN
        chk("r33 neg", bus.pool_o, pfill(0));
`else
        chk("r33 neg", bus.pool_o, pfill(-20));
`endif

        // realign to a frame start, then four back-to-back rows
        tick(1'b1, rand_row(), "align0");
        tick(1'b1, rand_row(), "align1");
        for (int i = 0; i < ROWS; i++) tick(1'b1, rand_row(), "r34");
        tick(1'b1, fill(3), "r34wrap");

        // reset while an even row is held
        do_reset(2);
        tick(1'b1, fill(1), "r35a");
        tick(1'b1, fill(2), "r35b");
        chk("r35 max2", bus.pool_o, pfill(2));

        // unpaired row keeps busy high and output stable
        pool_a = bus.pool_o;
        tick(1'b1, rand_row(), "r36c");
        for (int i = 0; i < 4; i++) tick(1'b0, rand_row(), "r36hold");
        chk("r36 held", bus.pool_o, pool_a);
        tick(1'b1, rand_row(), "r36d");

        // random traffic, mixed gaps and bursts
        for (int i = 0; i < 60; i++) tick($urandom_range(0, 2) != 0, rand_row(), "rand");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/relu_maxpool.md
RELU_MAXPOOL -- requirements
Module: relu_maxpool

Interface
REQ-001 Parameter H, default 24, positions per input row.
REQ-002 Parameter K, default 8, channels per row.
REQ-003 Parameter DATA_WIDTH, default 8, signed element width.
REQ-004 Parameter ROWS, default 24, rows per frame; must be even.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 rst_n  input  1  reset: asynchronous, active-high.
REQ-007 row_i  input  [0:H*K*DATA_WIDTH-1]  one int8 row from the bias/requant stage; element (ch m, pos n) at bit offset (m*H+n)*DATA_WIDTH, MSB-first.
REQ-008 done_add_i  input  1  single-cycle pulse; row_i is valid in that cycle.
REQ-009 pool_o  output  [0:(H/2)*K*DATA_WIDTH-1]  pooled row; element (m,p) at offset (m*(H/2)+p)*DATA_WIDTH.
REQ-010 done_pool_o  output  1  single-cycle pulse; pool_o valid in that cycle and held until the next update.
REQ-011 frame_done_o  output  1  single-cycle pulse coincident with the done_pool_o of the last pooled row of a frame.
REQ-012 busy_o  output  1  high while an even row is buffered awaiting its pair.

Function
REQ-013 FSM states: IDLE (no row buffered), HOLD (even row buffered).
REQ-014 IDLE + done_add_i: capture row_i into the row buffer, go to HOLD; no output.
REQ-015 HOLD + done_add_i: compute each 2x2 window max over buffer positions 2p, 2p+1 and row_i positions 2p, 2p+1, per channel; register into pool_o; pulse done_pool_o the next cycle; return to IDLE.
REQ-016 Latency: done_pool_o asserts exactly 1 cycle after the second row's done_add_i.
REQ-017 Comparisons are signed DATA_WIDTH; ties return the equal value; no widening or saturation is needed.
REQ-018 Row counter counts accepted rows 0..ROWS-1 and wraps to 0 after row ROWS-1; frame_done_o pulses with the pooled output of rows ROWS-2/ROWS-1.
REQ-019 done_add_i while done_pool_o is high is accepted normally; back-to-back pulses on consecutive cycles are supported.
REQ-020 done_add_i asserted continuously counts as one row per cycle.
REQ-021 pool_o holds its last value between updates; the row buffer is not cleared on output.
REQ-022 busy_o equals (state == HOLD).

Reset
REQ-023 rst_n high clears to IDLE: row counter 0, row buffer 0, pool_o 0, done_pool_o 0, frame_done_o 0, busy_o 0.
REQ-024 Reset mid-frame discards the buffered row; the first done_add_i after release is treated as row 0 (even).
REQ-025 done_add_i during reset is ignored.

Configuration
REQ-026 Macro RELU_POOL_RELU_EN defined: each element is clamped to max(x,0) before pooling, so pool_o elements are never negative.
REQ-027 RELU_POOL_RELU_EN undefined: pure signed 2x2 max; negative results pass through.

Structure
REQ-028 Shared package cnn_pkg holds DATA_WIDTH, H, K, ROWS defaults and the FSM state typedef (IDLE, HOLD).
REQ-029 A single sub-module max4_s8 (four signed inputs, one output, combinational, ReLU under the macro) is instantiated H/2*K times.
REQ-030 Only the row buffer, pool_o, FSM, counter and the pulse flops are sequential.

Verification
REQ-031 Row0 all 5, Row1 all 9 -> one done_pool_o one cycle after Row1's pulse, all elements 9, busy_o high between rows.
REQ-032 Row0 ch0 pos0..3 = -3,7,-128,127; Row1 ch0 pos0..3 = 2,-1,0,-5 -> pool ch0 p0 = 7, p1 = 127.
REQ-033 All elements -20 in both rows -> 0 with RELU_POOL_RELU_EN, -20 without.
REQ-034 ROWS=4, four pulses on consecutive cycles -> two done_pool_o pulses; frame_done_o only on the second; counter wraps to 0.
REQ-035 Reset asserted after row 0 (HOLD), then rows A=1 and B=2 -> output max=2 after B; no output after A.
REQ-036 Third row pulse held with no fourth row -> busy_o stays high and pool_o keeps its previous value.
